// File: rtl/ofs_fim_mem_if_pkg.sv
// Shared constants for the EMIF-facing AXI-MM memory port: bus widths and
// default throttle/watchdog settings.
package ofs_fim_mem_if_pkg;

  localparam int AXI_MEM_ID_W   = 4;
  localparam int AXI_MEM_ADDR_W = 32;
  localparam int AXI_MEM_DATA_W = 64;
  localparam int AXI_MEM_LEN_W  = 8;

  // Outstanding limits sized so the EMIF controller command queue never overflows.
  localparam int AXI_MEM_MAX_WR_OUTSTANDING = 64;
  localparam int AXI_MEM_MAX_RD_OUTSTANDING = 64;
  // Cycles without any response progress before the watchdog fires.
  localparam int AXI_MEM_RESP_TIMEOUT       = 65535;

endpackage : ofs_fim_mem_if_pkg

// File: rtl/ofs_fim_emif_axi_mm_if.sv
// AXI-MM memory port bundle. The "emif" modport is the responder side
// (accepts AW/W/AR, returns B/R); the "user" modport is the requester side.
interface ofs_fim_emif_axi_mm_if;
  import ofs_fim_mem_if_pkg::*;

  logic                        clk;
  logic                        rst_n;

  // Write address
  logic [AXI_MEM_ID_W-1:0]     awid;
  logic [AXI_MEM_ADDR_W-1:0]   awaddr;
  logic [AXI_MEM_LEN_W-1:0]    awlen;
  logic [2:0]                  awsize;
  logic [1:0]                  awburst;
  logic                        awvalid;
  logic                        awready;
  // Write data
  logic [AXI_MEM_DATA_W-1:0]   wdata;
  logic [AXI_MEM_DATA_W/8-1:0] wstrb;
  logic                        wlast;
  logic                        wvalid;
  logic                        wready;
  // Write response
  logic [AXI_MEM_ID_W-1:0]     bid;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  // Read address
  logic [AXI_MEM_ID_W-1:0]     arid;
  logic [AXI_MEM_ADDR_W-1:0]   araddr;
  logic [AXI_MEM_LEN_W-1:0]    arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;
  logic                        arvalid;
  logic                        arready;
  // Read data
  logic [AXI_MEM_ID_W-1:0]     rid;
  logic [AXI_MEM_DATA_W-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rlast;
  logic                        rvalid;
  logic                        rready;

  modport emif (
    output clk, rst_n,
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

  modport user (
    input  clk, rst_n,
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

endinterface : ofs_fim_emif_axi_mm_if

// File: rtl/ofs_fim_emif_axi_mm_txn_counter.sv
// Outstanding-transaction counter: +1 on request handshake, -1 on closing
// response, holds on both. A close with nothing outstanding is reported as
// underflow and the count stays at zero.
module ofs_fim_emif_axi_mm_txn_counter #(
  parameter int MAX       = 64,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_inc,
  input  logic                 i_dec,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic                 o_ok,
  output logic                 o_underflow
);

  localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX);
  localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;

  // Next count and underflow detection
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_cnt_next  = r_cnt;
    o_underflow = 1'b0;
    case ({i_inc, i_dec})
      2'b10: w_cnt_next = r_cnt + ONE_C;
      2'b01: begin
        if (r_cnt == '0) o_underflow = 1'b1;
        else             w_cnt_next  = r_cnt - ONE_C;
      end
      default: w_cnt_next = r_cnt;
    endcase
  end

  // Count register
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses <= so every register samples pre-edge values.
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_cnt_next;
  end

  assign o_cnt = r_cnt;
  assign o_ok  = (r_cnt < MAX_C);

endmodule : ofs_fim_emif_axi_mm_txn_counter

// File: rtl/ofs_fim_emif_axi_mm_throttle.sv
// AXI-MM throttle in front of the EMIF controller: gates AW/AR once the
// outstanding limit is hit, watches for stalled responses and flags
// responses that have no matching request. All payloads pass through.
module ofs_fim_emif_axi_mm_throttle
  import ofs_fim_mem_if_pkg::*;
#(
  parameter int MAX_WR_OUTSTANDING = AXI_MEM_MAX_WR_OUTSTANDING,
  parameter int MAX_RD_OUTSTANDING = AXI_MEM_MAX_RD_OUTSTANDING,
  parameter int CNT_WIDTH          = 8,
  parameter int TIMEOUT_CYCLES     = AXI_MEM_RESP_TIMEOUT,
  parameter int TMO_WIDTH          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ofs_fim_emif_axi_mm_if.emif   afu_mem,
  ofs_fim_emif_axi_mm_if.user   emif_mem,
  input  logic                  err_clr,
  output logic [CNT_WIDTH-1:0]  wr_outstanding,
  output logic [CNT_WIDTH-1:0]  rd_outstanding,
  output logic                  timeout_err,
  output logic                  proto_err
);

  localparam logic [TMO_WIDTH-1:0] TMO_MAX_C = TMO_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [TMO_WIDTH-1:0] TMO_ONE_C = TMO_WIDTH'(1);

  logic                 w_wr_ok, w_rd_ok;
  logic                 w_aw_hs, w_b_hs, w_ar_hs, w_r_hs, w_r_last_hs;
  logic                 w_wr_underflow, w_rd_underflow;
  logic [CNT_WIDTH-1:0] w_wr_cnt, w_rd_cnt;
  logic [TMO_WIDTH-1:0] r_tmo_cnt, w_tmo_next;
  logic                 w_tmo_hit;
  logic                 r_timeout_err, r_proto_err;

  assign afu_mem.clk   = clk;
  assign afu_mem.rst_n = ~rst;

  // AW: payload straight through, valid/ready gated by the write limit
  assign emif_mem.awid    = afu_mem.awid;
  assign emif_mem.awaddr  = afu_mem.awaddr;
  assign emif_mem.awlen   = afu_mem.awlen;
  assign emif_mem.awsize  = afu_mem.awsize;
  assign emif_mem.awburst = afu_mem.awburst;
  assign emif_mem.awvalid = afu_mem.awvalid & w_wr_ok;
  assign afu_mem.awready  = emif_mem.awready & w_wr_ok;

  // W: never gated, data may legally lead its address
  assign emif_mem.wdata  = afu_mem.wdata;
  assign emif_mem.wstrb  = afu_mem.wstrb;
  assign emif_mem.wlast  = afu_mem.wlast;
  assign emif_mem.wvalid = afu_mem.wvalid;
  assign afu_mem.wready  = emif_mem.wready;

  // B
  assign afu_mem.bid     = emif_mem.bid;
  assign afu_mem.bresp   = emif_mem.bresp;
  assign afu_mem.bvalid  = emif_mem.bvalid;
  assign emif_mem.bready = afu_mem.bready;

  // AR: payload straight through, valid/ready gated by the read limit
  assign emif_mem.arid    = afu_mem.arid;
  assign emif_mem.araddr  = afu_mem.araddr;
  assign emif_mem.arlen   = afu_mem.arlen;
  assign emif_mem.arsize  = afu_mem.arsize;
  assign emif_mem.arburst = afu_mem.arburst;
  assign emif_mem.arvalid = afu_mem.arvalid & w_rd_ok;
  assign afu_mem.arready  = emif_mem.arready & w_rd_ok;

  // R
  assign afu_mem.rid     = emif_mem.rid;
  assign afu_mem.rdata   = emif_mem.rdata;
  assign afu_mem.rresp   = emif_mem.rresp;
  assign afu_mem.rlast   = emif_mem.rlast;
  assign afu_mem.rvalid  = emif_mem.rvalid;
  assign emif_mem.rready = afu_mem.rready;

  // Handshakes observed on the EMIF side
  assign w_aw_hs     = emif_mem.awvalid & emif_mem.awready;
  assign w_b_hs      = emif_mem.bvalid  & emif_mem.bready;
  assign w_ar_hs     = emif_mem.arvalid & emif_mem.arready;
  assign w_r_hs      = emif_mem.rvalid  & emif_mem.rready;
  assign w_r_last_hs = w_r_hs & emif_mem.rlast;

  ofs_fim_emif_axi_mm_txn_counter #(
    .MAX       (MAX_WR_OUTSTANDING),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_wr_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_inc       (w_aw_hs),
    .i_dec       (w_b_hs),
    .o_cnt       (w_wr_cnt),
    .o_ok        (w_wr_ok),
    .o_underflow (w_wr_underflow)
  );

  ofs_fim_emif_axi_mm_txn_counter #(
    .MAX       (MAX_RD_OUTSTANDING),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_rd_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_inc       (w_ar_hs),
    .i_dec       (w_r_last_hs),
    .o_cnt       (w_rd_cnt),
    .o_ok        (w_rd_ok),
    .o_underflow (w_rd_underflow)
  );

  // Watchdog: restart on idle or any response progress, else count up and saturate
  always_comb begin
    w_tmo_next = r_tmo_cnt;
    w_tmo_hit  = 1'b0;
    if (((w_wr_cnt == '0) && (w_rd_cnt == '0)) || w_b_hs || w_r_hs) begin
      w_tmo_next = '0;
    end else if (r_tmo_cnt != TMO_MAX_C) begin
      w_tmo_next = r_tmo_cnt + TMO_ONE_C;
      w_tmo_hit  = (r_tmo_cnt == TMO_MAX_C - TMO_ONE_C);
    end
  end

  // Watchdog counter and sticky error flags; a set wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_tmo_cnt     <= w_tmo_next;
      r_timeout_err <= (r_timeout_err & ~err_clr) | w_tmo_hit;
      r_proto_err   <= (r_proto_err & ~err_clr) | w_wr_underflow | w_rd_underflow;
    end
  end

  assign wr_outstanding = w_wr_cnt;
  assign rd_outstanding = w_rd_cnt;
  assign timeout_err    = r_timeout_err;
  assign proto_err      = r_proto_err;

endmodule : ofs_fim_emif_axi_mm_throttle

// File: tb/tb_ofs_fim_emif_axi_mm_throttle.sv
// Bench for the AXI-MM throttle: the bench plays both the AFU requester and
// the EMIF responder. A transaction-level model tracks outstanding counts,
// the watchdog and the sticky flags and is compared every cycle; directed
// steps add literal expectations from the test plan.
module tb_ofs_fim_emif_axi_mm_throttle;

  localparam int MAX_WR  = 4;
  localparam int MAX_RD  = 4;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 100;
  localparam int TMO_W   = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             err_clr = 1'b0;
  logic [CNT_W-1:0] wr_outstanding, rd_outstanding;
  logic             timeout_err, proto_err;

  int n_cmp = 0;
  int n_bad = 0;

  ofs_fim_emif_axi_mm_if afu_mem ();
  ofs_fim_emif_axi_mm_if emif_mem ();

  assign emif_mem.clk   = clk;
  assign emif_mem.rst_n = ~rst;

  always #5 clk = ~clk;

  ofs_fim_emif_axi_mm_throttle #(
    .MAX_WR_OUTSTANDING (MAX_WR),
    .MAX_RD_OUTSTANDING (MAX_RD),
    .CNT_WIDTH          (CNT_W),
    .TIMEOUT_CYCLES     (TIMEOUT),
    .TMO_WIDTH          (TMO_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .afu_mem        (afu_mem),
    .emif_mem       (emif_mem),
    .err_clr        (err_clr),
    .wr_outstanding (wr_outstanding),
    .rd_outstanding (rd_outstanding),
    .timeout_err    (timeout_err),
    .proto_err      (proto_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit m_live = 1'b0;
  int m_wr = 0, m_rd = 0, m_tmo = 0;
  bit m_terr = 1'b0, m_perr = 1'b0;

  always @(negedge clk) begin
    bit wr_ok, rd_ok, aw_hs, b_hs, ar_hs, r_hs, rl_hs, pset, tset;
    int nw, nr, nt;
    wr_ok = (m_wr < MAX_WR);
    rd_ok = (m_rd < MAX_RD);
    if (m_live) begin
      check("wr_outstanding", wr_outstanding, m_wr);
      check("rd_outstanding", rd_outstanding, m_rd);
      check("timeout_err", timeout_err, m_terr);
      check("proto_err", proto_err, m_perr);
      check("emif_awvalid", emif_mem.awvalid, afu_mem.awvalid && wr_ok);
      check("afu_awready", afu_mem.awready, emif_mem.awready && wr_ok);
      check("emif_arvalid", emif_mem.arvalid, afu_mem.arvalid && rd_ok);
      check("afu_arready", afu_mem.arready, emif_mem.arready && rd_ok);
      check("awaddr_pass", emif_mem.awaddr, afu_mem.awaddr);
      check("arlen_pass", emif_mem.arlen, afu_mem.arlen);
      check("wvalid_pass", emif_mem.wvalid, afu_mem.wvalid);
      check("bvalid_pass", afu_mem.bvalid, emif_mem.bvalid);
      check("rdata_pass", afu_mem.rdata, emif_mem.rdata);
      check("rlast_pass", afu_mem.rlast, emif_mem.rlast);
    end
    aw_hs = afu_mem.awvalid && emif_mem.awready && wr_ok;
    b_hs  = emif_mem.bvalid && afu_mem.bready;
    ar_hs = afu_mem.arvalid && emif_mem.arready && rd_ok;
    r_hs  = emif_mem.rvalid && afu_mem.rready;
    rl_hs = r_hs && emif_mem.rlast;
    if (rst) begin
      m_wr = 0; m_rd = 0; m_tmo = 0; m_terr = 1'b0; m_perr = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      pset = 1'b0;
      nw = m_wr + int'(aw_hs) - int'(b_hs);
      if (nw < 0) begin nw = 0; pset = 1'b1; end
      nr = m_rd + int'(ar_hs) - int'(rl_hs);
      if (nr < 0) begin nr = 0; pset = 1'b1; end
      if ((m_wr == 0 && m_rd == 0) || b_hs || r_hs) nt = 0;
      else nt = (m_tmo < TIMEOUT) ? m_tmo + 1 : m_tmo;
      tset   = (nt == TIMEOUT) && (m_tmo != TIMEOUT);
      m_terr = (m_terr && !err_clr) || tset;
      m_perr = (m_perr && !err_clr) || pset;
      m_wr = nw; m_rd = nr; m_tmo = nt;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    afu_mem.awid = '0; afu_mem.awaddr = 32'h1000_0040; afu_mem.awlen = '0;
    afu_mem.awsize = 3'd3; afu_mem.awburst = 2'b01; afu_mem.awvalid = 1'b0;
    afu_mem.wdata = 64'hDEAD_BEEF_0000_0001; afu_mem.wstrb = '1; afu_mem.wlast = 1'b1;
    afu_mem.wvalid = 1'b0; afu_mem.bready = 1'b1;
    afu_mem.arid = '0; afu_mem.araddr = 32'h2000_0080; afu_mem.arlen = '0;
    afu_mem.arsize = 3'd3; afu_mem.arburst = 2'b01; afu_mem.arvalid = 1'b0;
    afu_mem.rready = 1'b1;
    emif_mem.awready = 1'b0; emif_mem.wready = 1'b1;
    emif_mem.bid = '0; emif_mem.bresp = '0; emif_mem.bvalid = 1'b0;
    emif_mem.arready = 1'b1;
    emif_mem.rid = '0; emif_mem.rdata = 64'h0; emif_mem.rresp = '0;
    emif_mem.rlast = 1'b0; emif_mem.rvalid = 1'b0;

    // Reset state; AW open after reset
    repeat (2) tick();
    check("rst_wr", wr_outstanding, 0);
    check("rst_rd", rd_outstanding, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_perr", proto_err, 0);
    emif_mem.awready = 1'b1;
    #1;
    check("rst_awready_open", afu_mem.awready, 1);
    rst = 1'b0;
    tick();

    // Write limit: 6 AW offered, EMIF withholds B
    afu_mem.awvalid = 1'b1; afu_mem.wvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      afu_mem.awaddr = 32'h1000_0000 + 32'(i * 64);
      tick();
    end
    check("lim_wr4", wr_outstanding, 4);
    check("lim_awready0", afu_mem.awready, 0);
    check("lim_emif_awvalid0", emif_mem.awvalid, 0);
    emif_mem.bvalid = 1'b1;
    tick();
    emif_mem.bvalid = 1'b0;
    check("lim_after_b_wr3", wr_outstanding, 3);
    check("lim_5th_awready", afu_mem.awready, 1);
    tick();
    check("lim_5th_accepted", wr_outstanding, 4);
    afu_mem.awvalid = 1'b0; afu_mem.wvalid = 1'b0;

    // Simultaneous AW + B at wr_cnt=3
    emif_mem.bvalid = 1'b1;
    tick();
    check("sim_pre_wr3", wr_outstanding, 3);
    afu_mem.awvalid = 1'b1;
    tick();
    afu_mem.awvalid = 1'b0;
    check("sim_aw_b_wr3", wr_outstanding, 3);
    repeat (3) tick();
    emif_mem.bvalid = 1'b0;
    check("drain_wr0", wr_outstanding, 0);
    check("drain_perr0", proto_err, 0);

    // Underflow: B with nothing outstanding
    emif_mem.bvalid = 1'b1;
    tick();
    check("uf_perr1", proto_err, 1);
    check("uf_wr0", wr_outstanding, 0);
    err_clr = 1'b1;
    tick();
    emif_mem.bvalid = 1'b0;
    check("uf_set_beats_clr", proto_err, 1);
    tick();
    err_clr = 1'b0;
    check("uf_cleared", proto_err, 0);

    // Read burst of 8 beats
    afu_mem.arvalid = 1'b1; afu_mem.arlen = 8'd7;
    tick();
    afu_mem.arvalid = 1'b0;
    check("burst_rd1", rd_outstanding, 1);
    emif_mem.rvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      emif_mem.rdata = 64'hA5A5_0000_0000_0000 + 64'(i);
      emif_mem.rlast = (i == 7);
      tick();
      check("burst_rd", rd_outstanding, (i < 7) ? 1 : 0);
    end
    emif_mem.rvalid = 1'b0; emif_mem.rlast = 1'b0;

    // Simultaneous AR + R-last at rd_cnt=2
    afu_mem.arlen = 8'd0; afu_mem.arvalid = 1'b1;
    repeat (2) tick();
    emif_mem.rvalid = 1'b1; emif_mem.rlast = 1'b1;
    tick();
    afu_mem.arvalid = 1'b0;
    check("sim_ar_rl_rd2", rd_outstanding, 2);
    repeat (2) tick();
    emif_mem.rvalid = 1'b0; emif_mem.rlast = 1'b0;
    check("sim_drain_rd0", rd_outstanding, 0);

    // Watchdog: one AR outstanding, no R
    afu_mem.arvalid = 1'b1;
    tick();
    afu_mem.arvalid = 1'b0;
    check("tmo_rd1", rd_outstanding, 1);
    repeat (99) tick();
    check("tmo_99_clear", timeout_err, 0);
    tick();
    check("tmo_100_set", timeout_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("tmo_clr", timeout_err, 0);
    tick();
    check("tmo_no_reassert", timeout_err, 0);
    emif_mem.rvalid = 1'b1; emif_mem.rlast = 1'b1;
    tick();
    emif_mem.rvalid = 1'b0; emif_mem.rlast = 1'b0;
    check("tmo_close_rd0", rd_outstanding, 0);

    // Watchdog restart: non-last R beat at cycle 99
    afu_mem.arvalid = 1'b1; afu_mem.arlen = 8'd1;
    tick();
    afu_mem.arvalid = 1'b0;
    repeat (98) tick();
    emif_mem.rvalid = 1'b1;
    tick();
    emif_mem.rvalid = 1'b0;
    repeat (60) tick();
    check("tmo_restart_noerr", timeout_err, 0);
    check("tmo_restart_rd1", rd_outstanding, 1);
    repeat (40) tick();
    check("tmo_restart_full", timeout_err, 1);
    err_clr = 1'b1;
    emif_mem.rvalid = 1'b1; emif_mem.rlast = 1'b1;
    tick();
    err_clr = 1'b0;
    emif_mem.rvalid = 1'b0; emif_mem.rlast = 1'b0;
    check("tmo_restart_done", rd_outstanding, 0);

    // Reset mid-operation with wr=3, rd=2 and a timeout flagged
    afu_mem.arlen = 8'd0;
    afu_mem.awvalid = 1'b1;
    repeat (3) tick();
    afu_mem.awvalid = 1'b0;
    afu_mem.arvalid = 1'b1;
    repeat (2) tick();
    afu_mem.arvalid = 1'b0;
    check("mid_wr3", wr_outstanding, 3);
    check("mid_rd2", rd_outstanding, 2);
    repeat (100) tick();
    check("mid_terr1", timeout_err, 1);
    rst = 1'b1; emif_mem.awready = 1'b0;
    tick();
    check("mid_rst_wr0", wr_outstanding, 0);
    check("mid_rst_rd0", rd_outstanding, 0);
    check("mid_rst_terr0", timeout_err, 0);
    check("mid_rst_perr0", proto_err, 0);
    check("mid_rst_awready_follow0", afu_mem.awready, 0);
    emif_mem.awready = 1'b1;
    #1;
    check("mid_rst_awready_follow1", afu_mem.awready, 1);
    rst = 1'b0;
    tick();
    emif_mem.bvalid = 1'b1;
    tick();
    emif_mem.bvalid = 1'b0;
    check("inflight_b_perr", proto_err, 1);
    check("inflight_b_wr0", wr_outstanding, 0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ofs_fim_emif_axi_mm_throttle
